// File: rtl/regfile_pkg.sv
// Shared widths and constants for the register-file writeback arbiter.
package regfile_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int REG_ADDR_W  = 5;
  localparam int REG_DATA_W  = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer just past the winner whenever the grant is acknowledged.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  input  logic          ack_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            scan;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    scan        = 0;
    for (int k = 0; k < N; k++) begin
      scan = (int'(ptr_q) + k) % N;
      if (en_i && !found && req_i[scan]) begin
        grant_o[scan] = 1'b1;
        grant_idx_o   = PW'(scan);
        found         = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ack_i) begin
      ptr_d = (grant_idx_o == PW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback sources
// with round-robin arbitration and a one-cycle registered write stage.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = regfile_pkg::NUM_REQ_DEF,
  parameter int ADDR_W  = regfile_pkg::REG_ADDR_W,
  parameter int DATA_W  = regfile_pkg::REG_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  RegWrite,
  output logic [ADDR_W-1:0]     WriteAddr,
  output logic [DATA_W-1:0]     WriteData
);
  import regfile_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: write i is consumed at a posedge where req_valid[i] & req_ready[i];
  // ready is a pure function of valid, stall, reset and the pointer, never of past offers.
  logic              grant_en;
  logic              hs;
  logic [PW-1:0]     win;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] data_d, data_q;

  assign grant_en = ~stall & rst_n;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid),
    .en_i        (grant_en),
    .ack_i       (hs),
    .grant_o     (req_ready),
    .grant_idx_o (win)
  );

  assign hs       = |req_ready;
  assign sel_addr = req_addr[win*ADDR_W +: ADDR_W];
  assign sel_data = req_data[win*DATA_W +: DATA_W];

  // r0 writes are consumed but never reach the port; addr/data keep the last real write.
  always_comb begin
    we_d   = hs && (sel_addr != ADDR_W'(REG_ZERO));
    addr_d = addr_q;
    data_d = data_q;
    if (we_d) begin
      addr_d = sel_addr;
      data_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign RegWrite  = we_q;
  assign WriteAddr = addr_q;
  assign WriteData = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a round-robin reference model.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  // clock / reset
  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            RegWrite;
  logic [AW-1:0]   WriteAddr;
  logic [DW-1:0]   WriteData;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .RegWrite  (RegWrite),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData)
  );

  // register file fed by the DUT's write port
  logic [DW-1:0] rf [32];
  always @(posedge clk) if (RegWrite) rf[WriteAddr] <= WriteData;

  // reference model and scoreboard
  int            errors = 0;
  int            checks = 0;
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_rf [32];
  logic [AW+DW-1:0] exp_q[$];

  function automatic int model_grant(input logic [N-1:0] v, input logic st);
    if (st) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    return (g < 0) ? '0 : N'(1 << g);
  endfunction

  task automatic model_edge(input int g);
    logic [AW-1:0] a;
    if (m_we) m_rf[m_addr] = m_data;
    m_we = 1'b0;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      a = req_addr[g*AW +: AW];
      if (a != 0) begin
        m_we   = 1'b1;
        m_addr = a;
        m_data = req_data[g*DW +: DW];
      end
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // driver tasks
  task automatic apply_reset();
    req_valid = '0;
    stall     = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one cycle, returns ready seen before the edge and the model's grant.
  task automatic drive_cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                             input logic [N*DW-1:0] d, input logic st,
                             output logic [N-1:0] rdy, output int g);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    stall     = st;
    #1;
    rdy = req_ready;
    g   = model_grant(v, st);
    @(posedge clk);
    model_edge(g);
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] rdy;
    int g;
    apply_reset();
    checks++;
    if (RegWrite !== 1'b0 || WriteAddr !== '0 || WriteData !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h expected 0/0/0", RegWrite, WriteAddr, WriteData);
    end
    drive_cycle(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hA5A5_0001, 32'd0}, 1'b0, rdy, g);
    checks++;
    if (RegWrite !== 1'b1 || WriteAddr !== 5'd7) begin
      errors++;
      $display("FAIL reset_prewrite: got we=%b addr=%h expected 1/07", RegWrite, WriteAddr);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (RegWrite !== 1'b0 || WriteAddr !== '0 || WriteData !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_async: got we=%b addr=%h data=%h rdy=%b expected 0/0/0/000",
               RegWrite, WriteAddr, WriteData, req_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    drive_cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'd3, 32'd2, 32'd1}, 1'b0, rdy, g);
    checks++;
    if (rdy !== 3'b001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected 001", rdy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rdy;
    int g;
    logic [N*DW-1:0] d;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom, $urandom};
      drive_cycle(3'b111, {5'd12, 5'd11, 5'd10}, d, 1'b0, rdy, g);
      checks++;
      if (rdy !== N'(1 << (i % N))) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", i, rdy, N'(1 << (i % N)));
      end
      checks++;
      if (RegWrite !== 1'b1 || WriteAddr !== AW'(10 + i % N) || WriteData !== d[(i%N)*DW +: DW]) begin
        errors++;
        $display("FAIL rr_write[%0d]: got we=%b addr=%0d data=%h expected 1/%0d/%h",
                 i, RegWrite, WriteAddr, WriteData, 10 + i % N, d[(i%N)*DW +: DW]);
      end
    end
  endtask

  task automatic test_single_and_zero();
    logic [N-1:0] rdy;
    int g;
    apply_reset();
    drive_cycle(3'b100, {5'd9, 5'd0, 5'd0}, {32'hDEADBEEF, 64'd0}, 1'b0, rdy, g);
    checks++;
    if (rdy !== 3'b100) begin
      errors++;
      $display("FAIL single_ready: got %b expected 100", rdy);
    end
    checks++;
    if (RegWrite !== 1'b1 || WriteAddr !== 5'd9 || WriteData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h expected 1/9/deadbeef", RegWrite, WriteAddr, WriteData);
    end
    // pointer is now 0; a zero-register write from source 1
    drive_cycle(3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'h1234, 32'd0}, 1'b0, rdy, g);
    checks++;
    if (rdy !== 3'b010 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg: got rdy=%b we=%b expected 010/0", rdy, RegWrite);
    end
    checks++;
    if (rf[9] !== 32'hDEADBEEF || rf[0] !== 32'd0) begin
      errors++;
      $display("FAIL rf_read: got r9=%h r0=%h expected deadbeef/0", rf[9], rf[0]);
    end
    checks++;
    if (WriteAddr !== 5'd9 || WriteData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL zero_hold: got addr=%0d data=%h expected 9/deadbeef", WriteAddr, WriteData);
    end
    drive_cycle(3'b111, {5'd1, 5'd1, 5'd1}, {32'd7, 32'd6, 32'd5}, 1'b0, rdy, g);
    checks++;
    if (rdy !== 3'b100) begin
      errors++;
      $display("FAIL zero_ptr_advance: got %b expected 100", rdy);
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] rdy;
    int g;
    apply_reset();
    drive_cycle(3'b001, {5'd0, 5'd0, 5'd4}, {64'd0, 32'd44}, 1'b0, rdy, g);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(3'b111, {5'd6, 5'd5, 5'd4}, {32'd3, 32'd2, 32'd1}, 1'b1, rdy, g);
      checks++;
      if (rdy !== 3'b000 || RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: got rdy=%b we=%b expected 000/0", i, rdy, RegWrite);
      end
    end
    drive_cycle(3'b111, {5'd6, 5'd5, 5'd4}, {32'd3, 32'd2, 32'd1}, 1'b0, rdy, g);
    checks++;
    if (rdy !== 3'b010 || RegWrite !== 1'b1 || WriteAddr !== 5'd5 || WriteData !== 32'd2) begin
      errors++;
      $display("FAIL stall_resume: got rdy=%b we=%b addr=%0d data=%h expected 010/1/5/2",
               rdy, RegWrite, WriteAddr, WriteData);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] rdy0, rdy1;
    logic         we0, we1;
    int g;
    apply_reset();
    drive_cycle(3'b011, {5'd0, 5'd3, 5'd3}, {32'd0, 32'd22, 32'd11}, 1'b0, rdy0, g);
    we0 = RegWrite;
    drive_cycle(3'b010, {5'd0, 5'd3, 5'd3}, {32'd0, 32'd22, 32'd11}, 1'b0, rdy1, g);
    we1 = RegWrite;
    checks++;
    if (rdy0 !== 3'b001 || rdy1 !== 3'b010 || we0 !== 1'b1 || we1 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handshake: got rdy=%b,%b we=%b,%b expected 001,010 1,1", rdy0, rdy1, we0, we1);
    end
    drive_cycle(3'b000, '0, '0, 1'b0, rdy0, g);
    checks++;
    if (rf[3] !== 32'd22) begin
      errors++;
      $display("FAIL b2b_final: got r3=%h expected 00000016", rf[3]);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]    pv, rdy;
    logic [N*AW-1:0] pa;
    logic [N*DW-1:0] pd;
    logic            st;
    logic [AW+DW-1:0] e;
    int g;
    apply_reset();
    pv = '0;
    pa = '0;
    pd = '0;
    exp_q.delete();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          pa[i*AW +: AW] = AW'($urandom_range(0, 7));
          pd[i*DW +: DW] = $urandom;
        end
      end
      st = ($urandom_range(0, 4) == 0);
      drive_cycle(pv, pa, pd, st, rdy, g);
      if (g >= 0) pv[g] = 1'b0;
      if (m_we) exp_q.push_back({m_addr, m_data});
      checks++;
      if (rdy !== onehot(g) || RegWrite !== m_we) begin
        errors++;
        $display("FAIL rand_cycle[%0d]: got rdy=%b we=%b expected %b/%b", c, rdy, RegWrite, onehot(g), m_we);
      end
      if (RegWrite === 1'b1) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if ({WriteAddr, WriteData} !== e) begin
          errors++;
          $display("FAIL rand_write[%0d]: got %h:%h expected %h:%h", c, WriteAddr, WriteData, e[DW +: AW], e[DW-1:0]);
        end
      end
      if (st && $urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
      end
    end
    drive_cycle('0, '0, '0, 1'b0, rdy, g);
    for (int r = 1; r < 32; r++) begin
      checks++;
      if (rf[r] !== m_rf[r]) begin
        errors++;
        $display("FAIL rand_rf[%0d]: got %h expected %h", r, rf[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) begin
      rf[r]   = '0;
      m_rf[r] = '0;
    end
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    stall     = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_round_robin();
    test_single_and_zero();
    test_stall();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
